// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/return sequencer. Drains older work, writes mepc/mcause/mstatus
// through the CSR write port, then redirects fetch to mtvec (trap) or mepc (return).
module trap_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pipe_busy_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mstatus_i,
  output logic            csr_wr_en_o,
  output logic [11:0]     csr_wr_idx_o,
  output logic [XLEN-1:0] csr_wr_data_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  localparam logic [11:0]     CsrMepc    = 12'h341;
  localparam logic [11:0]     CsrMcause  = 12'h342;
  localparam logic [11:0]     CsrMstatus = 12'h300;
  // Environment call from M-mode; interrupt bit clear.
  localparam logic [XLEN-1:0] CauseEcallM = XLEN'(11);

  localparam int unsigned MieBit  = 3;
  localparam int unsigned MpieBit = 7;
  localparam int unsigned MppLo   = 11;
  localparam int unsigned MppHi   = 12;

  localparam logic KindTrap   = 1'b0;
  localparam logic KindReturn = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StWrEpc,
    StWrCause,
    StWrStatus,
    StRedirect
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kind_q, kind_d;

  logic            accept;
  logic [XLEN-1:0] epc_aligned;
  logic [XLEN-1:0] mtvec_aligned;
  logic [XLEN-1:0] mepc_aligned;
  logic [XLEN-1:0] mstatus_trap;
  logic [XLEN-1:0] mstatus_ret;

  // Instruction addresses are 4-byte aligned; the two LSBs of these inputs are dropped.
  logic unused_lsbs;
  assign unused_lsbs = ^{pc_q[1:0], mtvec_i[1:0], mepc_i[1:0]};

  // Gating with rst_n keeps every output low for the whole reset, even if events toggle.
  assign accept = rst_n & (state_q == StIdle) & (ecall_i | mret_i);

  assign epc_aligned   = {pc_q[XLEN-1:2], 2'b00};
  assign mtvec_aligned = {mtvec_i[XLEN-1:2], 2'b00};
  assign mepc_aligned  = {mepc_i[XLEN-1:2], 2'b00};

  // mstatus update for trap entry and for mret; untouched bits pass through.
  always_comb begin
    mstatus_trap                = mstatus_i;
    mstatus_trap[MpieBit]       = mstatus_i[MieBit];
    mstatus_trap[MieBit]        = 1'b0;
    mstatus_trap[MppHi:MppLo]   = 2'b11;

    mstatus_ret                 = mstatus_i;
    mstatus_ret[MieBit]         = mstatus_i[MpieBit];
    mstatus_ret[MpieBit]        = 1'b1;
    // M-only core: MPP stays at machine mode.
    mstatus_ret[MppHi:MppLo]    = 2'b11;
  end

  // State, captured PC and trap/return kind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      kind_q  <= KindTrap;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kind_q  <= kind_d;
    end
  end

  // Next-state logic; events outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kind_d  = kind_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pc_d    = pc_i;
          // Simultaneous ecall and mret resolves to a trap.
          kind_d  = ecall_i ? KindTrap : KindReturn;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!pipe_busy_i) begin
          state_d = (kind_q == KindTrap) ? StWrEpc : StWrStatus;
        end
      end
      StWrEpc:    state_d = StWrCause;
      StWrCause:  state_d = StWrStatus;
      StWrStatus: state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Output decode; CSR port and redirect PC are zero whenever not in use.
  always_comb begin
    csr_wr_en_o   = 1'b0;
    csr_wr_idx_o  = '0;
    csr_wr_data_o = '0;
    flush_o       = 1'b0;
    stall_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    busy_o        = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          flush_o = 1'b1;
          stall_o = 1'b1;
        end
      end
      StDrain: begin
        stall_o = 1'b1;
      end
      StWrEpc: begin
        stall_o       = 1'b1;
        csr_wr_en_o   = 1'b1;
        csr_wr_idx_o  = CsrMepc;
        csr_wr_data_o = epc_aligned;
      end
      StWrCause: begin
        stall_o       = 1'b1;
        csr_wr_en_o   = 1'b1;
        csr_wr_idx_o  = CsrMcause;
        csr_wr_data_o = CauseEcallM;
      end
      StWrStatus: begin
        stall_o       = 1'b1;
        csr_wr_en_o   = 1'b1;
        csr_wr_idx_o  = CsrMstatus;
        csr_wr_data_o = (kind_q == KindTrap) ? mstatus_trap : mstatus_ret;
      end
      StRedirect: begin
        flush_o       = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = (kind_q == KindTrap) ? mtvec_aligned : mepc_aligned;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule
